// File: rtl/pwm_det_axil_responder.sv
// pwm_det_axil_responder: AXI4-Lite slave holding four 32-bit control registers for the PWM detection core.
module pwm_det_axil_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3
);
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic                          aw_held, w_held;
    logic [1:0]                    aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]                 w_strb;
    logic                          aw_hs, w_hs, ar_hs, commit;
    logic [1:0]                    wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]                 wr_strb;
    logic                          unused_ok;

    assign S_AXI_AWREADY = !S_AXI_ARESET && !aw_held && !S_AXI_BVALID;
    assign S_AXI_WREADY  = !S_AXI_ARESET && !w_held && !S_AXI_BVALID;
    assign S_AXI_ARREADY = !S_AXI_ARESET && !S_AXI_RVALID;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    // A held half merges with a live handshake of the other half, so commit needs no extra cycle.
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_idx  = aw_held ? aw_idx : S_AXI_AWADDR[3:2];
    assign wr_data = w_held ? w_data : S_AXI_WDATA;
    assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;

    assign slv_reg0 = regs[0];
    assign slv_reg1 = regs[1];
    assign slv_reg2 = regs[2];
    assign slv_reg3 = regs[3];

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
        end else begin
            if (commit) begin
                for (int i = 0; i < NB; i++)
                    if (wr_strb[i]) regs[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_held <= 1'b1;
                    aw_idx  <= S_AXI_AWADDR[3:2];
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                    w_data <= S_AXI_WDATA;
                    w_strb <= S_AXI_WSTRB;
                end
                if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            end
            // Reads sample the pre-edge register, so a same-edge write is not visible yet.
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= regs[S_AXI_ARADDR[3:2]];
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end
endmodule

// File: doc/pwm_det_axil_responder.md
PWM_DET_AXIL_RESPONDER -- requirements
Module: pwm_det_axil_responder

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering 4 registers.
REQ-003 SHALL have port S_AXI_ACLK, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port S_AXI_ARESET, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports S_AXI_AWADDR (input, ADDR_WIDTH), S_AXI_AWPROT (input, 3), S_AXI_AWVALID (input, 1) and S_AXI_AWREADY (output, 1), the write address channel.
REQ-006 SHALL have ports S_AXI_WDATA (input, 32), S_AXI_WSTRB (input, 4), S_AXI_WVALID (input, 1) and S_AXI_WREADY (output, 1), the write data channel.
REQ-007 SHALL have ports S_AXI_BRESP (output, 2), S_AXI_BVALID (output, 1) and S_AXI_BREADY (input, 1), the write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR (input, ADDR_WIDTH), S_AXI_ARPROT (input, 3), S_AXI_ARVALID (input, 1) and S_AXI_ARREADY (output, 1), the read address channel.
REQ-009 SHALL have ports S_AXI_RDATA (output, 32), S_AXI_RRESP (output, 2), S_AXI_RVALID (output, 1) and S_AXI_RREADY (input, 1), the read data channel.
REQ-010 SHALL have ports slv_reg0..slv_reg3, output, 32 each, current register contents driven to the PWM detection core.

Function
REQ-011 SHALL decode the register index from address bits [3:2]; bits [1:0] and AxPROT are ignored.
REQ-012 SHALL drive AWREADY high exactly when no write address is held and BVALID is low.
REQ-013 SHALL drive WREADY high exactly when no write data is held and BVALID is low.
REQ-014 SHALL capture AWADDR on an AW handshake and WDATA/WSTRB on a W handshake, independently and in either order, including the same cycle.
REQ-015 SHALL commit the write on the first rising edge where both address and data are held (or complete handshake), update the register per byte where WSTRB[i]=1, clear both holds, and set BVALID=1 with BRESP=2'b00 on that same edge.
REQ-016 SHALL give AW and W in the same cycle a latency of one cycle to BVALID and to the register update.
REQ-017 SHALL hold BVALID and BRESP stable until the BREADY handshake, clear BVALID on that edge, and accept no further AW or W while BVALID=1.
REQ-018 SHALL drive ARREADY high exactly when RVALID is low.
REQ-019 SHALL, on an AR handshake, load RDATA with the addressed register on the next edge and set RVALID=1 with RRESP=2'b00.
REQ-020 SHALL hold RDATA and RRESP stable until the RREADY handshake, then clear RVALID.
REQ-021 SHALL return the pre-write value when a read and a write commit to the same register on the same edge.
REQ-022 SHALL operate the read and write channels fully concurrently; neither blocks the other.
REQ-023 SHALL still accept and commit a write with WSTRB=4'b0000, leaving the register unchanged, with BRESP=OKAY.
REQ-024 SHALL drive slv_regN directly from the register flops, with changes visible one cycle after the commit edge.

Reset
REQ-025 SHALL, while S_AXI_ARESET=1 at a rising edge, clear all registers, address/data holds, BVALID, RVALID, RDATA, BRESP and RRESP to 0.
REQ-026 SHALL drive AWREADY, WREADY and ARREADY to 0 during reset and to 1 in the first cycle after reset.
REQ-027 SHALL discard an in-flight transaction (held AW or W, pending B or R) when reset is asserted mid-operation, with no register update.

Verification
REQ-028 SHALL be verified by writing 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x0, 0x4, 0x8 and 0xC with WSTRB=F, then reading each back -> data matches and every BRESP and RRESP is 00.
REQ-029 SHALL be verified by writing reg1=0xFFFFFFFF, then 0x12345678 with WSTRB=4'b0101 -> reading 0x4 returns 0xFF34FF78.
REQ-030 SHALL be verified by presenting W two cycles before AW, with BREADY low for 3 cycles -> BVALID rises one cycle after AW, holds 3 cycles, and AWREADY/WREADY stay 0 until the B handshake.
REQ-031 SHALL be verified by a same-edge read of 0x8 and write of 0xCAFEF00D to 0x8 over old value 0xDEAD0011 -> read returns 0xDEAD0011 and the next read returns 0xCAFEF00D.
REQ-032 SHALL be verified by asserting reset one cycle after an AW handshake with W pending -> no register change, all outputs 0, and a subsequent read of 0x0 returns 0x00000000.
